// File: rtl/can_host_pkg.sv
// Shared types and defaults for the CAN host-side register bus initiator.
// The verify-phase states exist only when CAN_HOST_WR_VERIFY_EN is defined.
package can_host_pkg;

  localparam int CAN_ADDR_W   = 5;
  localparam int CAN_DATA_W   = 8;
  localparam int CAN_NUM_REGS = 31;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    ACCESS        = 3'd1,
    GAP           = 3'd2,
    RESP          = 3'd3
`ifdef CAN_HOST_WR_VERIFY_EN
    ,
    VERIFY_ACCESS = 3'd4,
    VERIFY_GAP    = 3'd5
`endif
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/can_host_cycle_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded interval.
// A load of N therefore yields exactly N cycles before done is consumed.
module can_host_cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = (count_reg == W'(1));

endmodule

// File: rtl/can_host_bus_master.sv
// Single-command initiator driving the CAN controller register bus (cs/r_neg_w/addr/wdata).
// Optional write read-back verification is compiled in with CAN_HOST_WR_VERIFY_EN.
module can_host_bus_master
  import can_host_pkg::*;
#(
  parameter int ADDR_W        = CAN_ADDR_W,
  parameter int DATA_W        = CAN_DATA_W,
  parameter int NUM_REGS      = CAN_NUM_REGS,
  parameter int ACCESS_CYCLES = 3,
  parameter int IDLE_GAP      = 1
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_rnw,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_cs,
  output logic              o_r_neg_w,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [DATA_W-1:0] i_rdata
);

  localparam int CW = $clog2(max_int(ACCESS_CYCLES, IDLE_GAP) + 1);
  localparam logic [CW-1:0]   ACC_L      = CW'(ACCESS_CYCLES);
  localparam logic [CW-1:0]   GAP_L      = CW'(IDLE_GAP);
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  generate
    if (ACCESS_CYCLES < 1 || IDLE_GAP < 1 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_cfg
      $error("can_host_bus_master: illegal ACCESS_CYCLES/IDLE_GAP/NUM_REGS configuration");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic              rnw_reg, rnw_next;
  logic              cs_reg, cs_next;
  logic              bus_rnw_reg, bus_rnw_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic              timer_load;
  logic [CW-1:0]     timer_val;
  logic              timer_done;

  can_host_cycle_timer #(.W(CW)) u_timer (
    .clk      (i_sys_clk),
    .srst     (i_reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      rnw_reg     <= 1'b0;
      cs_reg      <= 1'b0;
      bus_rnw_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rnw_reg     <= rnw_next;
      cs_reg      <= cs_next;
      bus_rnw_reg <= bus_rnw_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rnw_next     = rnw_reg;
    cs_next      = cs_reg;
    bus_rnw_next = bus_rnw_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    timer_load   = 1'b0;
    timer_val    = ACC_L;

    case (state_reg)
      IDLE: begin
        if (i_cmd_valid) begin
          if ({1'b0, i_cmd_addr} < NUM_REGS_L) begin
            rnw_next     = i_cmd_rnw;
            addr_next    = i_cmd_addr;
            wdata_next   = i_cmd_wdata;
            cs_next      = 1'b1;
            bus_rnw_next = i_cmd_rnw;
            timer_load   = 1'b1;
            timer_val    = ACC_L;
            state_next   = ACCESS;
          end else begin
            // Out-of-range index: answer immediately without touching the bus.
            err_next   = 1'b1;
            rdata_next = '0;
            state_next = RESP;
          end
        end
      end

      ACCESS: begin
        if (timer_done) begin
          rdata_next   = rnw_reg ? i_rdata : '0;
          err_next     = 1'b0;
          cs_next      = 1'b0;
          bus_rnw_next = 1'b0;
          timer_load   = 1'b1;
          timer_val    = GAP_L;
          state_next   = GAP;
        end
      end

      GAP: begin
        if (timer_done) begin
`ifdef CAN_HOST_WR_VERIFY_EN
          if (!rnw_reg) begin
            cs_next      = 1'b1;
            bus_rnw_next = 1'b1;
            timer_load   = 1'b1;
            timer_val    = ACC_L;
            state_next   = VERIFY_ACCESS;
          end else begin
            state_next = RESP;
          end
`else
          state_next = RESP;
`endif
        end
      end

`ifdef CAN_HOST_WR_VERIFY_EN
      VERIFY_ACCESS: begin
        if (timer_done) begin
          rdata_next   = i_rdata;
          err_next     = (i_rdata != wdata_reg);
          cs_next      = 1'b0;
          bus_rnw_next = 1'b0;
          timer_load   = 1'b1;
          timer_val    = GAP_L;
          state_next   = VERIFY_GAP;
        end
      end

      VERIFY_GAP: begin
        if (timer_done) begin
          state_next = RESP;
        end
      end
`endif

      RESP: begin
        if (i_rsp_ready) begin
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_cmd_ready = (state_reg == IDLE);
  assign o_rsp_valid = (state_reg == RESP);
  assign o_rsp_rdata = rdata_reg;
  assign o_rsp_err   = err_reg;
  assign o_cs        = cs_reg;
  assign o_r_neg_w   = bus_rnw_reg;
  assign o_addr      = addr_reg;
  assign o_wdata     = wdata_reg;

endmodule
